spi_target: RTL and testbench
=============================

# spi_target

System-clock-domain SPI mode-0 target (peripheral) byte shifter. Oversamples the external SCK, /CS and MOSI on `clk_i`, shifts received bits in MSB-first, and shifts transmit bits out MSB-first. It presents each completed receive byte with a one-cycle strobe and reloads the transmit byte between bytes. It sits between the board SPI pins and the command/register decoder.

## Interface
- No parameters.
- `clk_i` in 1: system clock; all state is clocked on its rising edge.
- `reset_i` in 1: reset, synchronous and active-high.
- `spi_sck_i` in 1: SPI clock from the controller; asynchronous to `clk_i`; idles low (mode 0).
- `spi_cs_ni` in 1: chip select, active low, asynchronous.
- `spi_rx_i` in 1: serial data from the controller (MOSI), asynchronous.
- `spi_tx_o` out 1: serial data to the controller (MISO), registered, always driven (no tri-state).
- `tx_data_i` in 8: next byte to transmit; must be stable while it is sampled.
- `rx_data_o` out 8: last completed received byte; holds until the next byte completes.
- `cycle_o` out 1: one-`clk_i` strobe, high in the cycle `rx_data_o` updates.

## Operation
- Input conditioning: `spi_sck_i`, `spi_cs_ni` and `spi_rx_i` pass through identical synchronizer stages, so the three stay mutually aligned. Edges are detected by comparing the synchronized SCK with its value one cycle earlier.
- Internal state:
  - `bit_cnt`: 3 bits, counts 0..7 and wraps.
  - `rx_sr`: 7-bit receive shift register.
  - `tx_sr`: 8-bit transmit shift register.
  - `load_pend`: 1-bit reload flag.
- /CS high (synchronized):
  - `bit_cnt` = 0 and `load_pend` = 0.
  - `tx_sr` <= `tx_data_i` every cycle; `spi_tx_o` <= `tx_data_i[7]`.
  - SCK edges are ignored.
- SCK rising edge with /CS low:
  - If `bit_cnt` < 7: `rx_sr` <= {`rx_sr[5:0]`, rx}.
  - If `bit_cnt` = 7: `rx_data_o` <= {`rx_sr`, rx}, `cycle_o` = 1 for that cycle, and `load_pend` <= 1.
  - `bit_cnt` increments and wraps 7 to 0.
- SCK falling edge with /CS low:
  - If `load_pend` = 1: `tx_sr` <= `tx_data_i`, `spi_tx_o` <= `tx_data_i[7]`, `load_pend` <= 0.
  - Otherwise: `tx_sr` shifts left and `spi_tx_o` <= the new `tx_sr[7]`.
- First byte of a transfer: loaded while /CS is high, so its MSB is on `spi_tx_o` before the first SCK rising edge.
- `tx_data_i` is sampled only while /CS is high and on the reload falling edge. Changes at any other time have no effect.
- /CS rising mid-byte aborts the byte: partial bits are discarded, `cycle_o` does not pulse, and `rx_data_o` is unchanged.
- Simultaneous /CS rise and SCK edge in the same synchronized cycle: /CS wins and the edge is ignored.
- Back-to-back bytes need no /CS toggle; bytes stream continuously and `cycle_o` pulses once per byte.

## Timing
- Reset values: `spi_tx_o` = 0, `rx_data_o` = 8'h00, `cycle_o` = 0; `bit_cnt`, `rx_sr`, `tx_sr`, `load_pend` and synchronizers all 0. Reset overrides all other activity, including a transfer in progress.
- Input latency: L = 2 `clk_i` cycles with synchronizers (default), L = 1 without.
- `cycle_o` and `rx_data_o` update L+1 cycles after the 8th SCK rising edge at the pin.
- `spi_tx_o` changes L+1 cycles after an SCK falling edge at the pin.
- Constraints on the controller (with L = 2):
  - SCK high and low phases ≥ 4 `clk_i` periods.
  - /CS held stable ≥ 3 `clk_i` periods before the first SCK rising edge and after the last SCK falling edge.
  - Violating these gives undefined data, but the block must never lock up; the next /CS high always restores the idle state.
- `cycle_o` is never high for two consecutive cycles.

## Configuration
- `SPI_TARGET_SYNC_EN` defined (default build):
  - Each input uses a two-flop synchronizer before edge detection, so L = 2.
- Not defined:
  - Each input is registered once, so L = 1.
  - For use only when the SCK, /CS and MOSI sources are already synchronous to `clk_i`.
  - Functional behaviour is identical; only latency differs.

## Test plan
- Reset: assert `reset_i` mid-transfer -> `spi_tx_o` = 0, `rx_data_o` = 8'h00, `cycle_o` = 0; the next transfer completes normally.
- Single byte: `tx_data_i` = 8'hA5 while /CS high, controller sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; one `cycle_o` pulse with `rx_data_o` = 8'h3C.
- Streaming: three bytes 8'h01, 8'h80, 8'hFF with one /CS low and `tx_data_i` changed after each `cycle_o` to 8'h55 then 8'hAA -> three `cycle_o` pulses with matching `rx_data_o`; MISO carries the initial byte, then 8'h55, then 8'hAA.
- TX hold: toggle `tx_data_i` on every bit mid-byte -> MISO unaffected until the reload falling edge.
- Abort: /CS rises after 5 bits of 8'hF0 -> no `cycle_o`, `rx_data_o` unchanged; the next full byte 8'h12 is received correctly.
- Minimum timing: SCK phases of exactly 4 `clk_i` periods, random data loopback of 256 bytes -> all bytes match in both directions.

Source files
------------

// File: rtl/spi_target.sv
// SPI mode-0 target byte shifter, oversampling SCK, /CS and MOSI on clk_i.
// Define SPI_TARGET_SYNC_EN for two-flop input synchronizers (L=2); otherwise inputs are registered once (L=1).
module spi_target (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       spi_sck_i,
   input  logic       spi_cs_ni,
   input  logic       spi_rx_i,
   output logic       spi_tx_o,
   input  logic [7:0] tx_data_i,
   output logic [7:0] rx_data_o,
   output logic       cycle_o
);

   // Synchronized pins packed as {sck, cs_n, rx} so all three share one pipeline.
   logic [2:0] sync_d, sync_q;

`ifdef SPI_TARGET_SYNC_EN
   logic [2:0] meta_d, meta_q;

   always_comb begin
      meta_d = {spi_sck_i, spi_cs_ni, spi_rx_i};
      sync_d = meta_q;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         meta_q <= 3'b000;
      end else begin
         meta_q <= meta_d;
      end
   end
`else
   always_comb begin
      sync_d = {spi_sck_i, spi_cs_ni, spi_rx_i};
   end
`endif

   logic       sck_s, cs_n_s, rx_s, sck_rise_s, sck_fall_s;
   logic       sck_prev_d, sck_prev_q;
   logic [2:0] bit_cnt_d, bit_cnt_q;
   logic [6:0] rx_sr_d, rx_sr_q;
   logic [7:0] tx_sr_d, tx_sr_q;
   logic       load_pend_d, load_pend_q;
   logic [7:0] rx_data_d, rx_data_q;
   logic       cycle_d, cycle_q;
   logic       tx_d, tx_q;

   always_comb begin
      sck_s       = sync_q[2];
      cs_n_s      = sync_q[1];
      rx_s        = sync_q[0];
      sck_rise_s  = sck_s & ~sck_prev_q;
      sck_fall_s  = ~sck_s & sck_prev_q;

      sck_prev_d  = sck_s;
      bit_cnt_d   = bit_cnt_q;
      rx_sr_d     = rx_sr_q;
      tx_sr_d     = tx_sr_q;
      load_pend_d = load_pend_q;
      rx_data_d   = rx_data_q;
      cycle_d     = 1'b0;
      tx_d        = tx_q;

      // A deasserted /CS takes priority over any SCK edge seen in the same cycle.
      if (cs_n_s) begin
         bit_cnt_d   = 3'd0;
         load_pend_d = 1'b0;
         tx_sr_d     = tx_data_i;
         tx_d        = tx_data_i[7];
      end else if (sck_rise_s) begin
         if (bit_cnt_q == 3'd7) begin
            rx_data_d   = {rx_sr_q, rx_s};
            cycle_d     = 1'b1;
            load_pend_d = 1'b1;
         end else begin
            rx_sr_d = {rx_sr_q[5:0], rx_s};
         end
         bit_cnt_d = bit_cnt_q + 3'd1;
      end else if (sck_fall_s) begin
         if (load_pend_q) begin
            tx_sr_d     = tx_data_i;
            tx_d        = tx_data_i[7];
            load_pend_d = 1'b0;
         end else begin
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
            tx_d    = tx_sr_q[6];
         end
      end else begin
         bit_cnt_d = bit_cnt_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync_q      <= 3'b000;
         sck_prev_q  <= 1'b0;
         bit_cnt_q   <= 3'd0;
         rx_sr_q     <= 7'h00;
         tx_sr_q     <= 8'h00;
         load_pend_q <= 1'b0;
         rx_data_q   <= 8'h00;
         cycle_q     <= 1'b0;
         tx_q        <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         sck_prev_q  <= sck_prev_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_sr_q     <= rx_sr_d;
         tx_sr_q     <= tx_sr_d;
         load_pend_q <= load_pend_d;
         rx_data_q   <= rx_data_d;
         cycle_q     <= cycle_d;
         tx_q        <= tx_d;
      end
   end

   assign spi_tx_o  = tx_q;
   assign rx_data_o = rx_data_q;
   assign cycle_o   = cycle_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: table-driven single bytes plus streaming, hold, abort, reset and loopback runs.
module tb_spi_target;

`ifdef SPI_TARGET_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int HP = 4;

   logic       clk_i = 1'b0;
   logic       reset_i = 1'b1;
   logic       spi_sck_i = 1'b0;
   logic       spi_cs_ni = 1'b1;
   logic       spi_rx_i = 1'b0;
   logic       spi_tx_o;
   logic [7:0] tx_data_i = 8'h00;
   logic [7:0] rx_data_o;
   logic       cycle_o;

   spi_target dut (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .spi_sck_i (spi_sck_i),
      .spi_cs_ni (spi_cs_ni),
      .spi_rx_i  (spi_rx_i),
      .spi_tx_o  (spi_tx_o),
      .tx_data_i (tx_data_i),
      .rx_data_o (rx_data_o),
      .cycle_o   (cycle_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [7:0] tx;
      logic [7:0] mosi;
      logic [7:0] exp_miso;
      logic [7:0] exp_rx;
   } vec_t;

   vec_t       vecs [5];
   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         pulses = 0;
   int         pulse_cyc = 0;
   int         rise_cyc = 0;
   logic [7:0] last_rx = 8'h00;
   logic [7:0] next_tx = 8'h00;
   bit         next_valid = 1'b0;
   bit         prev_cycle = 1'b0;
   bit         toggle_en = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_i);
         cyc++;
         if (cycle_o) begin
            check("cycle_o_single_cycle", {31'd0, prev_cycle}, 32'd0);
            pulses++;
            pulse_cyc = cyc;
            last_rx   = rx_data_o;
            if (next_valid) begin
               tx_data_i  = next_tx;
               next_valid = 1'b0;
            end
         end
         prev_cycle = cycle_o;
      end
   endtask

   task automatic xfer(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
      miso = 8'h00;
      for (int b = 0; b < nbits; b++) begin
         spi_rx_i = mosi[7-b];
         if (toggle_en && b > 0) tx_data_i = ~tx_data_i;
         tick(HP);
         miso[7-b] = spi_tx_o;
         spi_sck_i = 1'b1;
         rise_cyc  = cyc;
         tick(HP);
         spi_sck_i = 1'b0;
      end
   endtask

   task automatic cs_low();
      spi_cs_ni = 1'b0;
      tick(HP);
   endtask

   task automatic cs_high();
      tick(HP);
      spi_cs_ni = 1'b1;
      tick(HP);
   endtask

   initial begin
      logic [7:0] miso;
      logic [7:0] mosi;
      logic [7:0] cur_tx;
      logic [7:0] nxt;

      vecs[0] = '{tx: 8'hA5, mosi: 8'h3C, exp_miso: 8'hA5, exp_rx: 8'h3C};
      vecs[1] = '{tx: 8'h00, mosi: 8'hFF, exp_miso: 8'h00, exp_rx: 8'hFF};
      vecs[2] = '{tx: 8'hFF, mosi: 8'h00, exp_miso: 8'hFF, exp_rx: 8'h00};
      vecs[3] = '{tx: 8'h81, mosi: 8'h7E, exp_miso: 8'h81, exp_rx: 8'h7E};
      vecs[4] = '{tx: 8'h6C, mosi: 8'hB2, exp_miso: 8'h6C, exp_rx: 8'hB2};

      // Reset state
      tick(3);
      check("reset_tx", {31'd0, spi_tx_o}, 32'd0);
      check("reset_rx", {24'd0, rx_data_o}, 32'h00);
      check("reset_cycle", {31'd0, cycle_o}, 32'd0);
      reset_i   = 1'b0;
      tx_data_i = 8'h80;
      tick(HP);
      check("idle_tx_msb", {31'd0, spi_tx_o}, 32'd1);

      // Table-driven single-byte transfers
      for (int v = 0; v < 5; v++) begin
         tx_data_i = vecs[v].tx;
         tick(HP);
         pulses = 0;
         cs_low();
         xfer(vecs[v].mosi, 8, miso);
         if (v == 0) check("cycle_latency", pulse_cyc - rise_cyc, LAT + 1);
         cs_high();
         check("vec_miso", {24'd0, miso}, {24'd0, vecs[v].exp_miso});
         check("vec_pulses", pulses, 1);
         check("vec_rx_strobe", {24'd0, last_rx}, {24'd0, vecs[v].exp_rx});
         check("vec_rx_hold", {24'd0, rx_data_o}, {24'd0, vecs[v].exp_rx});
      end

      // Streaming three bytes under one /CS
      tx_data_i = 8'hC3;
      tick(HP);
      pulses = 0;
      cs_low();
      next_tx = 8'h55; next_valid = 1'b1;
      xfer(8'h01, 8, miso);
      check("stream0_miso", {24'd0, miso}, 32'hC3);
      check("stream0_rx", {24'd0, last_rx}, 32'h01);
      next_tx = 8'hAA; next_valid = 1'b1;
      xfer(8'h80, 8, miso);
      check("stream1_miso", {24'd0, miso}, 32'h55);
      check("stream1_rx", {24'd0, last_rx}, 32'h80);
      xfer(8'hFF, 8, miso);
      check("stream2_miso", {24'd0, miso}, 32'hAA);
      check("stream2_rx", {24'd0, last_rx}, 32'hFF);
      cs_high();
      check("stream_pulses", pulses, 3);

      // tx_data_i toggling mid-byte must not disturb MISO
      tx_data_i = 8'hA5;
      tick(HP);
      cs_low();
      toggle_en = 1'b1;
      xfer(8'h3C, 8, miso);
      toggle_en = 1'b0;
      cs_high();
      check("hold_miso", {24'd0, miso}, 32'hA5);
      check("hold_rx", {24'd0, rx_data_o}, 32'h3C);

      // Abort after 5 bits, then a full byte
      pulses = 0;
      cs_low();
      xfer(8'hF0, 5, miso);
      cs_high();
      check("abort_pulses", pulses, 0);
      check("abort_rx_unchanged", {24'd0, rx_data_o}, 32'h3C);
      tx_data_i = 8'h96;
      tick(HP);
      cs_low();
      xfer(8'h12, 8, miso);
      cs_high();
      check("after_abort_rx", {24'd0, rx_data_o}, 32'h12);
      check("after_abort_miso", {24'd0, miso}, 32'h96);
      check("after_abort_pulses", pulses, 1);

      // Reset mid-transfer
      tx_data_i = 8'h5A;
      tick(HP);
      cs_low();
      xfer(8'hC3, 4, miso);
      spi_sck_i = 1'b1;
      tick(1);
      reset_i = 1'b1;
      tick(1);
      check("midreset_tx", {31'd0, spi_tx_o}, 32'd0);
      check("midreset_rx", {24'd0, rx_data_o}, 32'h00);
      check("midreset_cycle", {31'd0, cycle_o}, 32'd0);
      spi_sck_i = 1'b0;
      spi_cs_ni = 1'b1;
      tick(3);
      reset_i   = 1'b0;
      tx_data_i = 8'hE7;
      tick(HP);
      pulses = 0;
      cs_low();
      xfer(8'h7E, 8, miso);
      cs_high();
      check("postreset_rx", {24'd0, rx_data_o}, 32'h7E);
      check("postreset_miso", {24'd0, miso}, 32'hE7);
      check("postreset_pulses", pulses, 1);

      // 256-byte loopback at minimum SCK phases
      cur_tx    = 8'($urandom_range(0, 255));
      tx_data_i = cur_tx;
      tick(HP);
      pulses = 0;
      cs_low();
      for (int k = 0; k < 256; k++) begin
         mosi       = 8'($urandom_range(0, 255));
         nxt        = 8'($urandom_range(0, 255));
         next_tx    = nxt;
         next_valid = 1'b1;
         xfer(mosi, 8, miso);
         check("loop_miso", {24'd0, miso}, {24'd0, cur_tx});
         check("loop_rx", {24'd0, last_rx}, {24'd0, mosi});
         cur_tx = nxt;
      end
      cs_high();
      check("loop_pulses", pulses, 256);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
